// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for a five-stage pipeline.
//
// Ports:
//   clk          - system clock, all state updates on the rising edge
//   rst          - asynchronous active-low reset
//   stallreq_id  - load-use hazard from decode (single-cycle request)
//   stallreq_ex  - multi-cycle execute operation busy (level)
//   stallreq_mem - memory bus not ready (level)
//   flush_req    - exception flush (one-cycle pulse)
//   stall        - hold enables {mem_wb, ex_mem, id_ex, if_id, pc}, 1 = hold
//   bubble       - same mapping, 1 = load stage register with NOP this cycle
//   bus_err      - registered one-cycle pulse on memory-wait timeout
//   stall_cycles - saturating count of cycles with any stall bit set
//
// Memory waits are tracked by a RUN / MEM_WAIT / ERR_HOLD machine. A wait
// lasting TIMEOUT consecutive cycles raises bus_err and parks the machine in
// ERR_HOLD, where the memory request is no longer honoured until it drops.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             flush_req,
    output logic [4:0]       stall,
    output logic [4:0]       bubble,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR_HOLD
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout;
    logic       mem_accept;

    // Stage controls: zero-latency from inputs and current state.
    always_comb begin
        stall      = '0;
        bubble     = '0;
        mem_accept = stallreq_mem && (state != ERR_HOLD);
        if (rst) begin
            if (flush_req) begin
                stall  = 5'b00000;
                bubble = 5'b11110;
            end else if (mem_accept) begin
                // mem_wb takes a bubble so a held write is never repeated
                stall  = 5'b01111;
                bubble = 5'b10000;
            end else if (stallreq_ex) begin
                stall  = 5'b00111;
                bubble = 5'b01000;
            end else if (stallreq_id) begin
                stall  = 5'b00011;
                bubble = 5'b00100;
            end
        end
    end

    // Next-state / wait counter. The wait counter holds the number of wait
    // cycles already completed; a timeout fires in the cycle that completes
    // the TIMEOUT-th one, so bus_err is seen the following cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout      = 1'b0;
        if (flush_req) begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (stallreq_mem) begin
                        if (TIMEOUT == 1) begin
                            timeout      = 1'b1;
                            state_nxt    = ERR_HOLD;
                            wait_cnt_nxt = '0;
                        end else begin
                            state_nxt    = MEM_WAIT;
                            wait_cnt_nxt = 8'd1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (stallreq_mem) begin
                        if (wait_cnt + 8'd1 == 8'(TIMEOUT)) begin
                            timeout      = 1'b1;
                            state_nxt    = ERR_HOLD;
                            wait_cnt_nxt = '0;
                        end else begin
                            wait_cnt_nxt = wait_cnt + 8'd1;
                        end
                    end else begin
                        state_nxt    = RUN;
                        wait_cnt_nxt = '0;
                    end
                end
                ERR_HOLD: begin
                    if (!stallreq_mem) begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            bus_err  <= timeout;
            if ((stall != '0) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
